// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared state type, default size and bit-reversal helper for the FFT sequencer
package fft_pkg;

  localparam int N_LOG2_DEFAULT = 3;
  localparam int MAX_LOG2       = 6;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT,
    UNLOAD
  } state_e;

  // Reverse the low nbits bits of v; higher result bits are returned as zero.
  function automatic logic [MAX_LOG2-1:0] bitrev(input logic [MAX_LOG2-1:0] v, input int nbits);
    logic [MAX_LOG2-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LOG2; i++) begin
      if (i < nbits) r[nbits-1-i] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// rtl/fft_addr_gen.sv - combinational operand-address and twiddle-index generator for one butterfly
module fft_addr_gen #(
  parameter int N_LOG2 = 3,
  parameter int AW     = N_LOG2
) (
  input  logic [AW-1:0] stage_i,
  input  logic [AW-2:0] b_i,
  output logic [AW-1:0] addr_a_o,
  output logic [AW-1:0] addr_b_o,
  output logic [AW-2:0] tw_idx_o
);

  logic [AW-1:0] b_ext;
  logic [AW-1:0] half;
  logic [AW-1:0] pos;
  logic [AW-1:0] grp;
  logic [AW-1:0] a;
  logic [AW-1:0] tw_sh;

  // Split butterfly index into group and in-group position, then place the pair and its twiddle.
  always_comb begin
    b_ext    = {1'b0, b_i};
    half     = AW'(1) << stage_i;
    pos      = b_ext & (half - AW'(1));
    grp      = b_ext >> stage_i;
    a        = ((grp << stage_i) << 1) | pos;
    tw_sh    = AW'(N_LOG2 - 1) - stage_i;
    addr_a_o = a;
    addr_b_o = a + half;
    tw_idx_o = (AW-1)'(pos << tw_sh);
  end

endmodule

// File: rtl/fft_seq_ctrl.sv
// rtl/fft_seq_ctrl.sv - load/compute/unload sequencer for the shared-butterfly FFT (option: FFT_SEQ_CTRL_INVERSE_EN)
module fft_seq_ctrl
  import fft_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEFAULT,
  parameter int AW     = N_LOG2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          start,
`ifdef FFT_SEQ_CTRL_INVERSE_EN
  input  logic          inverse,
  output logic          bf_conj,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  output logic          ld_we,
  output logic [AW-1:0] ld_addr,
  output logic          bf_start,
  output logic [AW-1:0] bf_addr_a,
  output logic [AW-1:0] bf_addr_b,
  output logic [AW-2:0] bf_tw_idx,
  input  logic          bf_done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic          busy,
  output logic [AW-1:0] stage,
  output logic          done
);

  localparam logic [AW-1:0] LAST_IDX   = AW'((1 << N_LOG2) - 1);
  localparam logic [AW-2:0] LAST_B     = (AW-1)'((1 << (N_LOG2 - 1)) - 1);
  localparam logic [AW-1:0] LAST_STAGE = AW'(N_LOG2 - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;      // sample index while loading, result index while unloading
  logic [AW-1:0] stage_q, stage_d;
  logic [AW-2:0] b_q, b_d;          // butterfly index within the current stage

  logic [AW-1:0] gen_a;
  logic [AW-1:0] gen_b;
  logic [AW-2:0] gen_tw;

  fft_addr_gen #(
    .N_LOG2 (N_LOG2),
    .AW     (AW)
  ) u_addr_gen (
    .stage_i  (stage_q),
    .b_i      (b_q),
    .addr_a_o (gen_a),
    .addr_b_o (gen_b),
    .tw_idx_o (gen_tw)
  );

  // Phase and counter registers; ena low freezes all of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
      b_q     <= '0;
    end else if (ena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      b_q     <= b_d;
    end
  end

`ifdef FFT_SEQ_CTRL_INVERSE_EN
  logic inv_q;

  // Direction is captured only from a start pulse that actually launches a transform.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_q <= 1'b0;
    end else if (ena && state_q == IDLE && start) begin
      inv_q <= inverse;
    end
  end

  assign bf_conj = inv_q & ((state_q == ISSUE) | (state_q == WAIT));
`endif

  // Next-state and outputs; handshake strobes are masked by ena so nothing is accepted while frozen.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    b_d       = b_q;
    in_ready  = 1'b0;
    ld_we     = 1'b0;
    ld_addr   = '0;
    bf_start  = 1'b0;
    bf_addr_a = '0;
    bf_addr_b = '0;
    bf_tw_idx = '0;
    out_valid = 1'b0;
    out_addr  = '0;
    done      = 1'b0;
    busy      = (state_q != IDLE);
    stage     = stage_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end

      LOAD: begin
        in_ready = ena;
        ld_we    = in_valid & ena;
        ld_addr  = AW'(bitrev(MAX_LOG2'(cnt_q), N_LOG2));
        if (in_valid) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            stage_d = '0;
            b_d     = '0;
            state_d = ISSUE;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end

      ISSUE: begin
        bf_start  = ena;
        bf_addr_a = gen_a;
        bf_addr_b = gen_b;
        bf_tw_idx = gen_tw;
        state_d   = WAIT;
      end

      WAIT: begin
        bf_addr_a = gen_a;
        bf_addr_b = gen_b;
        bf_tw_idx = gen_tw;
        if (bf_done) begin
          if (b_q == LAST_B) begin
            b_d = '0;
            if (stage_q == LAST_STAGE) begin
              stage_d = '0;
              cnt_d   = '0;
              state_d = UNLOAD;
            end else begin
              stage_d = stage_q + AW'(1);
              state_d = ISSUE;
            end
          end else begin
            b_d     = b_q + (AW-1)'(1);
            state_d = ISSUE;
          end
        end
      end

      UNLOAD: begin
        out_valid = ena;
        out_addr  = cnt_q;
        if (out_ready) begin
          if (cnt_q == LAST_IDX) begin
            done    = ena;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
